json_stream_lexer: RTL and testbench
====================================

JSON_STREAM_LEXER -- requirements
Module: json_stream_lexer

Interface
REQ-001 SHALL have parameter MAX_DEPTH, default 16: maximum nesting depth of objects/arrays (1..64).
REQ-002 SHALL have parameter POS_W, default 32: width of byte-position counters.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: input byte valid.
REQ-006 SHALL have port in_ready, output, 1: input byte accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, 8: JSON document byte.
REQ-008 SHALL have port in_last, input, 1: byte is the last byte of the document.
REQ-009 SHALL have port tok_valid, output, 1: token output valid.
REQ-010 SHALL have port tok_ready, input, 1: downstream accepts token.
REQ-011 SHALL have port tok_kind, output, token_kind_e: OBJ_BEGIN, OBJ_END, ARR_BEGIN, ARR_END, COLON, COMMA, STRING, NUMBER, TRUE, FALSE, NULL.
REQ-012 SHALL have port tok_pos, output, POS_W: byte offset of the token's first byte.
REQ-013 SHALL have port tok_depth, output, $clog2(MAX_DEPTH+1): nesting level outside the token.
REQ-014 SHALL have port err_valid, output, 1: document in error.
REQ-015 SHALL have port err_kind, output, error_kind_e: UNEXPECTED_CHAR, BRACKET_MISMATCH, DEPTH_OVERFLOW, UNEXPECTED_EOI.
REQ-016 SHALL have port err_pos, output, POS_W: byte offset of the offending byte.
REQ-017 SHALL have port doc_done, output, 1: one-cycle pulse, document completed without error.

Function
REQ-018 SHALL implement FSM states IDLE, STR, STR_ESC, NUM, LIT, DRAIN.
REQ-019 IDLE: skip whitespace (0x20,0x09,0x0A,0x0D); { [ } ] : , emit their token immediately; '"' -> STR; '-' or digit -> NUM; 't','f','n' -> LIT; any other byte -> UNEXPECTED_CHAR.
REQ-020 STR: '\' -> STR_ESC; '"' emits STRING, -> IDLE; bytes < 0x20 -> UNEXPECTED_CHAR; STR_ESC consumes any one byte, -> STR.
REQ-021 NUM: accepts 0-9 . e E + -; on any other byte SHALL emit NUMBER without consuming it (in_ready=0 that cycle), -> IDLE, byte re-processed next cycle.
REQ-022 LIT: compares each byte to "true"/"false"/"null" by index counter; mismatch -> UNEXPECTED_CHAR; final char emits the literal token, -> IDLE.
REQ-023 Depth stack: { / [ push 1-bit type; } / ] SHALL pop and check type; mismatch or empty stack -> BRACKET_MISMATCH; push at depth MAX_DEPTH -> DEPTH_OVERFLOW.
REQ-024 tok_depth: depth before push for BEGIN, after pop for END, current depth otherwise.
REQ-025 Token output SHALL be a single registered stage; token appears the cycle after the completing byte is accepted (latency 1).
REQ-026 in_ready SHALL be 0 while tok_valid && !tok_ready and in the REQ-021 cycle; otherwise 1.
REQ-027 tok_* SHALL be held stable while tok_valid && !tok_ready.
REQ-028 Position counter SHALL increment per accepted byte, clear to 0 after an in_last byte; wrap-around at 2^POS_W is modulo.
REQ-029 in_last: NUM state emits NUMBER including that byte; STR, STR_ESC, incomplete LIT, or depth != 0 -> UNEXPECTED_EOI at that byte's position.
REQ-030 On error: err_valid=1 registered next cycle, err_kind/err_pos captured, first error only, no further tokens, state DRAIN.
REQ-031 DRAIN: in_ready=1, bytes discarded; on in_last accepted, err_valid clears next cycle, stack/counter cleared, -> IDLE.
REQ-032 doc_done SHALL pulse the cycle after an error-free in_last byte, concurrent with any final token.

Reset
REQ-033 On rst: state IDLE, depth 0, position 0, tok_valid 0, err_valid 0, doc_done 0, tok_*/err_* fields 0, in_ready 1 after release.
REQ-034 rst mid-token SHALL discard partial token and pending output token.

Structure
REQ-035 json_hw_pkg SHALL hold token_kind_e, error_kind_e, whitespace/delimiter constants.
REQ-036 Depth stack SHALL be sub-module json_depth_stack (push/pop/top, full/empty, MAX_DEPTH parameter).

Verification
REQ-037 '{"a":[1,true]}' -> OBJ_BEGIN p0 d0, STRING p1 d1, COLON p4, ARR_BEGIN p5 d1, NUMBER p6 d2, COMMA p7, TRUE p8 d2, ARR_END p12 d1, OBJ_END p13 d0, doc_done.
REQ-038 '[}' -> ARR_BEGIN p0, then err BRACKET_MISMATCH pos 1; '{' in DRAIN ignored.
REQ-039 MAX_DEPTH=4, '[[[[[' -> four ARR_BEGIN, DEPTH_OVERFLOW pos 4.
REQ-040 '"a\"b"' then ' 12' last -> STRING p0, NUMBER p7, doc_done.
REQ-041 tok_ready low 10 cycles during '[1,2]' -> in_ready low, all 5 tokens delivered in order, none lost.
REQ-042 rst asserted in STR mid '"abc', then '[]' last -> only ARR_BEGIN p0, ARR_END p1, doc_done.

Source files
------------

// File: rtl/json_hw_pkg.sv
// json_hw_pkg: shared types and character constants for the JSON lexer.
//   token_kind_e  : kinds of token reported on tok_kind
//   error_kind_e  : kinds of error reported on err_kind
//   lex_state_e   : lexer FSM states
//   helper functions classify bytes and look up literal spellings.
package json_hw_pkg;

   typedef enum logic [3:0] {
      OBJ_BEGIN, OBJ_END, ARR_BEGIN, ARR_END, COLON, COMMA,
      STRING, NUMBER, TRUE, FALSE, NULL
   } token_kind_e;

   typedef enum logic [1:0] {
      UNEXPECTED_CHAR, BRACKET_MISMATCH, DEPTH_OVERFLOW, UNEXPECTED_EOI
   } error_kind_e;

   typedef enum logic [2:0] {IDLE, STR, STR_ESC, NUM, LIT, DRAIN} lex_state_e;

   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_TAB    = 8'h09;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LBRACE = 8'h7B;
   localparam logic [7:0] CH_RBRACE = 8'h7D;
   localparam logic [7:0] CH_LBRACK = 8'h5B;
   localparam logic [7:0] CH_RBRACK = 8'h5D;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_QUOTE  = 8'h22;
   localparam logic [7:0] CH_BSLASH = 8'h5C;
   localparam logic [7:0] CH_MINUS  = 8'h2D;
   localparam logic [7:0] CH_PLUS   = 8'h2B;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_LO_E   = 8'h65;
   localparam logic [7:0] CH_UP_E   = 8'h45;
   localparam logic [7:0] CH_T      = 8'h74;
   localparam logic [7:0] CH_F      = 8'h66;
   localparam logic [7:0] CH_N      = 8'h6E;

   function automatic logic is_ws(input logic [7:0] c);
      return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic logic is_num_char(input logic [7:0] c);
      return is_digit(c) || (c == CH_DOT) || (c == CH_LO_E) || (c == CH_UP_E) ||
             (c == CH_PLUS) || (c == CH_MINUS);
   endfunction

   // sel: 0 = true, 1 = false, 2 = null. Returns the character at position idx.
   function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] idx);
      logic [39:0] s;
      case (sel)
         2'd0:    s = {"true", 8'h00};
         2'd1:    s = "false";
         default: s = {"null", 8'h00};
      endcase
      s = s << {idx, 3'b000};
      return s[39:32];
   endfunction

   function automatic logic [2:0] lit_last(input logic [1:0] sel);
      return (sel == 2'd1) ? 3'd4 : 3'd3;
   endfunction

endpackage

// File: rtl/json_depth_stack.sv
// json_depth_stack: bracket-type stack for the JSON lexer.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : empty the stack (end of document)
//   push        : push push_type (1 = array, 0 = object); ignored when full
//   pop         : discard the top entry; ignored when empty
//   top         : type of the innermost open bracket
//   depth       : number of open brackets
//   full, empty : depth == MAX_DEPTH, depth == 0
module json_depth_stack
#(
   parameter int MAX_DEPTH = 16,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               push,
   input  logic               pop,
   input  logic               push_type,
   output logic               top,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               empty
);

   // Entry 0 is the top of stack; pushes shift older entries upward.
   logic [MAX_DEPTH-1:0] types;

   assign full  = (depth == DEPTH_W'(MAX_DEPTH));
   assign empty = (depth == '0);
   assign top   = types[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
      end else if (clear) begin
         depth <= '0;
      end else if (push && !full) begin
         depth <= depth + 1'b1;
      end else if (pop && !empty) begin
         depth <= depth - 1'b1;
      end
   end

   // Contents are only meaningful below depth, so they need no reset.
   always_ff @(posedge clk) begin
      if (!clear && push && !full) begin
         types <= (types << 1) | MAX_DEPTH'(push_type);
      end else if (!clear && pop && !empty) begin
         types <= types >> 1;
      end
   end

endmodule

// File: rtl/json_stream_lexer.sv
// json_stream_lexer: byte-stream JSON tokenizer with bracket checking.
//   in_valid/in_ready/in_data/in_last : input byte stream, in_last ends a document
//   tok_valid/tok_ready               : token handshake (one registered stage)
//   tok_kind/tok_pos/tok_depth        : token kind, offset of first byte, nesting level
//   err_valid/err_kind/err_pos        : first error of the current document
//   doc_done                          : pulse after an error-free final byte
module json_stream_lexer
   import json_hw_pkg::*;
#(
   parameter int MAX_DEPTH = 16,
   parameter int POS_W     = 32
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [7:0]                     in_data,
   input  logic                           in_last,
   output logic                           tok_valid,
   input  logic                           tok_ready,
   output token_kind_e                    tok_kind,
   output logic [POS_W-1:0]               tok_pos,
   output logic [$clog2(MAX_DEPTH+1)-1:0] tok_depth,
   output logic                           err_valid,
   output error_kind_e                    err_kind,
   output logic [POS_W-1:0]               err_pos,
   output logic                           doc_done
);

   localparam int DW = $clog2(MAX_DEPTH + 1);

   lex_state_e        state, nxt;
   logic [POS_W-1:0]  pos, start_pos, emit_pos;
   logic [1:0]        lit_sel;
   logic [2:0]        lit_idx;
   logic              stall, num_flush, accept, num_stop;
   logic              emit, err, done, open, push, pop, clear;
   token_kind_e       emit_kind;
   error_kind_e       err_code;
   logic [DW-1:0]     emit_depth, depth_after, depth;
   logic              top, full, empty;

   assign stall     = tok_valid && !tok_ready;
   assign num_stop  = (state == NUM) && in_valid && !is_num_char(in_data);
   // A number ends on the first foreign byte: emit it and leave the byte for IDLE.
   assign num_flush = num_stop && !stall;
   assign in_ready  = (state == DRAIN) || (!stall && !num_stop);
   assign accept    = in_valid && in_ready;
   assign clear     = accept && in_last;

   json_depth_stack #(.MAX_DEPTH(MAX_DEPTH), .DEPTH_W(DW)) u_stack (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push),
      .pop       (pop),
      .push_type (in_data == CH_LBRACK),
      .top       (top),
      .depth     (depth),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      emit        = 1'b0;
      emit_kind   = OBJ_BEGIN;
      emit_pos    = pos;
      emit_depth  = depth;
      err         = 1'b0;
      err_code    = UNEXPECTED_CHAR;
      nxt         = state;
      open        = 1'b0;
      done        = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      depth_after = depth;
      if (num_flush) begin
         emit      = 1'b1;
         emit_kind = NUMBER;
         emit_pos  = start_pos;
         nxt       = IDLE;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (is_ws(in_data)) begin
                  open = 1'b0;
               end else if (in_data == CH_LBRACE || in_data == CH_LBRACK) begin
                  if (full) begin
                     err      = 1'b1;
                     err_code = DEPTH_OVERFLOW;
                  end else begin
                     emit      = 1'b1;
                     emit_kind = (in_data == CH_LBRACE) ? OBJ_BEGIN : ARR_BEGIN;
                     push      = 1'b1;
                  end
               end else if (in_data == CH_RBRACE || in_data == CH_RBRACK) begin
                  if (empty || (top != (in_data == CH_RBRACK))) begin
                     err      = 1'b1;
                     err_code = BRACKET_MISMATCH;
                  end else begin
                     emit       = 1'b1;
                     emit_kind  = (in_data == CH_RBRACE) ? OBJ_END : ARR_END;
                     emit_depth = depth - DW'(1);
                     pop        = 1'b1;
                  end
               end else if (in_data == CH_COLON) begin
                  emit      = 1'b1;
                  emit_kind = COLON;
               end else if (in_data == CH_COMMA) begin
                  emit      = 1'b1;
                  emit_kind = COMMA;
               end else if (in_data == CH_QUOTE) begin
                  nxt  = STR;
                  open = 1'b1;
               end else if (in_data == CH_MINUS || is_digit(in_data)) begin
                  nxt  = NUM;
                  open = 1'b1;
               end else if (in_data == CH_T || in_data == CH_F || in_data == CH_N) begin
                  nxt  = LIT;
                  open = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            STR: begin
               if (in_data == CH_BSLASH) begin
                  nxt  = STR_ESC;
                  open = 1'b1;
               end else if (in_data == CH_QUOTE) begin
                  emit      = 1'b1;
                  emit_kind = STRING;
                  emit_pos  = start_pos;
                  nxt       = IDLE;
               end else if (in_data < 8'h20) begin
                  err = 1'b1;
               end else begin
                  open = 1'b1;
               end
            end
            STR_ESC: begin
               nxt  = STR;
               open = 1'b1;
            end
            NUM: open = 1'b1;
            LIT: begin
               if (in_data != lit_char(lit_sel, lit_idx)) begin
                  err = 1'b1;
               end else if (lit_idx == lit_last(lit_sel)) begin
                  emit      = 1'b1;
                  emit_kind = (lit_sel == 2'd0) ? TRUE : (lit_sel == 2'd1) ? FALSE : NULL;
                  emit_pos  = start_pos;
                  nxt       = IDLE;
               end else begin
                  open = 1'b1;
               end
            end
            DRAIN: begin
               if (in_last) nxt = IDLE;
            end
            default: nxt = IDLE;
         endcase
         depth_after = depth + DW'(push) - DW'(pop);
         // A number running into the end of the document is complete with this byte.
         if (in_last && state != DRAIN && !err) begin
            if (nxt == NUM) begin
               emit      = 1'b1;
               emit_kind = NUMBER;
               emit_pos  = (state == NUM) ? start_pos : pos;
               nxt       = IDLE;
               open      = 1'b0;
            end
            if (open || depth_after != '0) begin
               err      = 1'b1;
               err_code = UNEXPECTED_EOI;
            end else begin
               done = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pos       <= '0;
         start_pos <= '0;
         lit_sel   <= 2'd0;
         lit_idx   <= 3'd0;
         tok_valid <= 1'b0;
         tok_kind  <= OBJ_BEGIN;
         tok_pos   <= '0;
         tok_depth <= '0;
         err_valid <= 1'b0;
         err_kind  <= UNEXPECTED_CHAR;
         err_pos   <= '0;
         doc_done  <= 1'b0;
      end else begin
         doc_done  <= done;
         // Error status lives for the rest of the document only.
         err_valid <= err || (state == DRAIN && !(accept && in_last));
         if (accept) pos <= in_last ? '0 : pos + 1'b1;
         if (accept && state == IDLE) begin
            start_pos <= pos;
            lit_idx   <= 3'd1;
            lit_sel   <= (in_data == CH_T) ? 2'd0 : (in_data == CH_F) ? 2'd1 : 2'd2;
         end else if (accept && state == LIT) begin
            lit_idx <= lit_idx + 1'b1;
         end
         if (emit && !err) begin
            tok_valid <= 1'b1;
            tok_kind  <= emit_kind;
            tok_pos   <= emit_pos;
            tok_depth <= emit_depth;
         end else if (tok_ready) begin
            tok_valid <= 1'b0;
         end
         if (err) begin
            err_kind <= err_code;
            err_pos  <= pos;
            state    <= in_last ? IDLE : DRAIN;
         end else begin
            state <= nxt;
         end
      end
   end

endmodule

// File: tb/tb_json_stream_lexer.sv
// tb_json_stream_lexer: scoreboard bench for json_stream_lexer (MAX_DEPTH=4).
module tb_json_stream_lexer;
   import json_hw_pkg::*;

   localparam int MAX_DEPTH = 4;
   localparam int POS_W     = 16;
   localparam int EV_TOK = 0, EV_ERR = 1, EV_DONE = 2;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           in_valid, in_ready, in_last, tok_valid, tok_ready;
   logic [7:0]                     in_data;
   token_kind_e                    tok_kind;
   logic [POS_W-1:0]               tok_pos, err_pos;
   logic [$clog2(MAX_DEPTH+1)-1:0] tok_depth;
   logic                           err_valid, doc_done;
   error_kind_e                    err_kind;

   always #5 clk = ~clk;

   json_stream_lexer #(.MAX_DEPTH(MAX_DEPTH), .POS_W(POS_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .tok_kind  (tok_kind),
      .tok_pos   (tok_pos),
      .tok_depth (tok_depth),
      .err_valid (err_valid),
      .err_kind  (err_kind),
      .err_pos   (err_pos),
      .doc_done  (doc_done)
   );

   typedef struct {
      int ev;
      int kind;
      int pos;
      int depth;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   logic err_seen = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_vec++;
      if (obs !== req) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, req);
      end
   endtask

   task automatic exp_tok(input token_kind_e k, input int p, input int d);
      exp_q.push_back('{EV_TOK, int'(k), p, d});
   endtask

   task automatic exp_err(input error_kind_e k, input int p);
      exp_q.push_back('{EV_ERR, int'(k), p, 0});
   endtask

   task automatic exp_done();
      exp_q.push_back('{EV_DONE, 0, 0, 0});
   endtask

   task automatic take(input int ev, input int kind, input int p, input int d);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_val("unexpected_event", 64'(ev), 64'(-1));
      end else begin
         e = exp_q.pop_front();
         check_val("event_type", 64'(ev), 64'(e.ev));
         if (e.ev == ev && ev != EV_DONE) begin
            check_val((ev == EV_TOK) ? "tok_kind" : "err_kind", 64'(kind), 64'(e.kind));
            check_val((ev == EV_TOK) ? "tok_pos" : "err_pos", 64'(p), 64'(e.pos));
            if (ev == EV_TOK) check_val("tok_depth", 64'(d), 64'(e.depth));
         end
      end
   endtask

   // Output monitor: tokens, completion pulses and error onsets in arrival order.
   always @(negedge clk) begin
      if (rst) begin
         err_seen = 1'b0;
      end else begin
         if (tok_valid && tok_ready) take(EV_TOK, int'(tok_kind), int'(tok_pos), int'(tok_depth));
         if (doc_done) take(EV_DONE, 0, 0, 0);
         if (err_valid && !err_seen) take(EV_ERR, int'(err_kind), int'(err_pos), 0);
         err_seen = err_valid;
      end
   end

   task automatic send(input logic [7:0] b, input logic last);
      int   n;
      logic acc;
      in_data  = b;
      in_last  = last;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check_val("accept_timeout", 64'(acc), 64'(1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input logic last);
      for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
   endtask

   task automatic settle(input string tag);
      repeat (4) @(posedge clk);
      #1;
      check_val(tag, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check_val("rst_tok_valid", 64'(tok_valid), 64'(0));
      check_val("rst_err_valid", 64'(err_valid), 64'(0));
      check_val("rst_doc_done", 64'(doc_done), 64'(0));
      check_val("rst_in_ready", 64'(in_ready), 64'(1));
      check_val("rst_tok_pos", 64'(tok_pos), 64'(0));
      check_val("rst_tok_depth", 64'(tok_depth), 64'(0));
      check_val("rst_err_pos", 64'(err_pos), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      tok_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_state();

      // Nested object/array document.
      exp_tok(OBJ_BEGIN, 0, 0);  exp_tok(STRING, 1, 1);   exp_tok(COLON, 4, 1);
      exp_tok(ARR_BEGIN, 5, 1);  exp_tok(NUMBER, 6, 2);   exp_tok(COMMA, 7, 2);
      exp_tok(TRUE, 8, 2);       exp_tok(ARR_END, 12, 1); exp_tok(OBJ_END, 13, 0);
      exp_done();
      send_str("{\"a\":[1,true]}", 1'b1);
      settle("doc1_drained");

      // Bracket mismatch, then a discarded byte in DRAIN.
      exp_tok(ARR_BEGIN, 0, 0);
      exp_err(BRACKET_MISMATCH, 1);
      send_str("[}", 1'b0);
      settle("mismatch_drained");
      check_val("drain_err_held", 64'(err_valid), 64'(1));
      send_str("{", 1'b1);
      @(negedge clk);
      check_val("drain_err_cleared", 64'(err_valid), 64'(0));
      check_val("drain_no_token", 64'(tok_valid), 64'(0));
      settle("drain_done");

      // Depth overflow at MAX_DEPTH=4.
      for (int i = 0; i < 4; i++) exp_tok(ARR_BEGIN, i, i);
      exp_err(DEPTH_OVERFLOW, 4);
      send_str("[[[[[", 1'b0);
      send_str("x", 1'b1);
      settle("overflow_drained");

      // Escaped quote in a string, then a number ended by in_last.
      exp_tok(STRING, 0, 0);
      exp_tok(NUMBER, 7, 0);
      exp_done();
      send_str("\"a\\\"b\"", 1'b0);
      send_str(" 12", 1'b1);
      settle("string_number_drained");

      // Downstream back-pressure for ten cycles.
      exp_tok(ARR_BEGIN, 0, 0); exp_tok(NUMBER, 1, 1); exp_tok(COMMA, 2, 1);
      exp_tok(NUMBER, 3, 1);    exp_tok(ARR_END, 4, 0);
      exp_done();
      tok_ready = 1'b0;
      fork
         send_str("[1,2]", 1'b1);
         begin
            repeat (5) @(negedge clk);
            check_val("stall_in_ready", 64'(in_ready), 64'(0));
            check_val("stall_tok_valid", 64'(tok_valid), 64'(1));
            check_val("stall_tok_kind", 64'(tok_kind), 64'(ARR_BEGIN));
            repeat (5) @(posedge clk);
            #1 tok_ready = 1'b1;
         end
      join
      settle("stall_drained");

      // Truncated literal and an illegal byte, each ending its document.
      exp_err(UNEXPECTED_EOI, 2);
      send_str("tru", 1'b1);
      settle("eoi_drained");
      exp_err(UNEXPECTED_CHAR, 0);
      send_str("@", 1'b1);
      settle("badchar_drained");

      // Reset in the middle of a string discards it.
      send_str("\"abc", 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_state();
      exp_tok(ARR_BEGIN, 0, 0);
      exp_tok(ARR_END, 1, 0);
      exp_done();
      send_str("[]", 1'b1);
      settle("after_reset_drained");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
